// File: rtl/valve_pkg.sv
// Shared types and helpers for the valve flow-control blocks.
package valve_pkg;

  localparam int DEF_N_CH     = 4;
  localparam int DEF_DEAD_CYC = 8;
  localparam int MAX_CH       = 64;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DEAD
  } valve_state_e;

  function automatic logic [MAX_CH-1:0] valve_onehot(input logic [5:0] idx);
    return MAX_CH'(1) << idx;
  endfunction

endpackage

// File: rtl/valve_hold_timer.sv
// Loadable down-counter; done_o strobes on the last counted cycle.
module valve_hold_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // A load of zero parks the counter at zero, so it never signals done.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = en_i && (cnt_q == W'(1));

endmodule

// File: rtl/valve_demux_seq.sv
// Clocked valve-channel demux with timed hold, preemption and
// break-before-make dead time between channel changes.
module valve_demux_seq
  import valve_pkg::*;
#(
  parameter int N_CH     = DEF_N_CH,
  parameter int SEL_W    = $clog2(N_CH),
  parameter int DUR_W    = 16,
  parameter int DEAD_CYC = DEF_DEAD_CYC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             in,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [SEL_W-1:0] req_sel,
  input  logic [DUR_W-1:0] req_dur,
  output logic [N_CH-1:0]  out,
  output logic [SEL_W-1:0] active_ch,
  output logic             busy,
  output logic             err_sel
);

  localparam int             DEAD_W = $clog2(DEAD_CYC + 1);
  localparam logic [SEL_W:0] N_CH_L = (SEL_W + 1)'(N_CH);

  valve_state_e     state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             pend_vld_q, pend_vld_d;
  logic [SEL_W-1:0] pend_sel_q, pend_sel_d;
  logic [DUR_W-1:0] pend_dur_q, pend_dur_d;
  logic [N_CH-1:0]  out_q, out_d;
  logic [SEL_W-1:0] ach_q;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic             sel_ok, acc, acc_ok;
  logic             hold_load, hold_done, dead_load, dead_done;
  logic [DUR_W-1:0] hold_val;

  assign sel_ok    = {1'b0, req_sel} < N_CH_L;
  assign req_ready = enable && (state_q != DEAD);
  assign acc       = req_valid && req_ready;
  assign acc_ok    = acc && sel_ok;

  valve_hold_timer #(.W(DUR_W)) u_hold (
    .clk,
    .rst_n,
    .load_i     (hold_load),
    .load_val_i (hold_val),
    .en_i       (state_q == ACTIVE),
    .done_o     (hold_done)
  );

  valve_hold_timer #(.W(DEAD_W)) u_dead (
    .clk,
    .rst_n,
    .load_i     (dead_load),
    .load_val_i (DEAD_W'(DEAD_CYC)),
    .en_i       (state_q == DEAD),
    .done_o     (dead_done)
  );

  // A new request outranks a coinciding hold expiry; a same-channel request
  // simply reloads the hold counter without passing through dead time.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    pend_vld_d = pend_vld_q;
    pend_sel_d = pend_sel_q;
    pend_dur_d = pend_dur_q;
    hold_load  = 1'b0;
    hold_val   = req_dur;
    dead_load  = 1'b0;
    err_d      = 1'b0;
    if (!enable) begin
      state_d    = IDLE;
      pend_vld_d = 1'b0;
    end else begin
      err_d = acc && !sel_ok;
      case (state_q)
        IDLE: begin
          if (acc_ok) begin
            state_d   = ACTIVE;
            sel_d     = req_sel;
            hold_load = 1'b1;
          end
        end
        ACTIVE: begin
          if (acc_ok && (req_sel == sel_q)) begin
            hold_load = 1'b1;
          end else if (acc_ok) begin
            pend_vld_d = 1'b1;
            pend_sel_d = req_sel;
            pend_dur_d = req_dur;
            state_d    = DEAD;
            dead_load  = 1'b1;
          end else if (hold_done) begin
            pend_vld_d = 1'b0;
            state_d    = DEAD;
            dead_load  = 1'b1;
          end
        end
        DEAD: begin
          if (dead_done) begin
            if (pend_vld_q) begin
              state_d    = ACTIVE;
              sel_d      = pend_sel_q;
              hold_load  = 1'b1;
              hold_val   = pend_dur_q;
              pend_vld_d = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output stage lags the state by one cycle, so busy/active_ch follow suit.
  always_comb begin
    out_d  = '0;
    busy_d = enable && (state_q != IDLE);
    if (enable && (state_q == ACTIVE)) begin
      out_d = N_CH'(valve_onehot(6'(sel_q))) & {N_CH{in}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      pend_vld_q <= 1'b0;
      out_q      <= '0;
      busy_q     <= 1'b0;
      ach_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      pend_vld_q <= pend_vld_d;
      out_q      <= out_d;
      busy_q     <= busy_d;
      ach_q      <= sel_q;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    pend_sel_q <= pend_sel_d;
    pend_dur_q <= pend_dur_d;
  end

  assign out       = out_q;
  assign busy      = busy_q;
  assign active_ch = ach_q;
  assign err_sel   = err_q;

endmodule
